// File: rtl/task_pkg.sv
// Shared types and constants for the task answer arbiter.
package task_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2
    } state_e;

    // Bytes carried by one beat of the default 32-bit answer channel.
    localparam int unsigned BYTES_PER_BEAT = 4;

    // Beats needed to carry a packet; an empty packet still occupies one beat.
    function automatic int unsigned beats_for_size(input int unsigned size_bytes,
                                                   input int unsigned bytes_per_beat);
        if (size_bytes == 0) begin
            return 1;
        end
        return (size_bytes + bytes_per_beat - 1) / bytes_per_beat;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority pick: first requester at or after the pointer, wrapping.
module rr_pick
    import task_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_any
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IW'((int'(i_ptr) + i) % NUM_REQ);
            if (!found && i_req[idx]) begin
                found       = 1'b1;
                o_gnt[idx]  = 1'b1;
                o_idx       = idx;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/task_answer_arbiter.sv
// Shares one answer channel between NUM_REQ task engines, one whole packet per grant.
module task_answer_arbiter
    import task_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SIZE_WIDTH = 12
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]              i_req_last,
    input  logic [NUM_REQ*SIZE_WIDTH-1:0]   i_req_size,
    output logic [NUM_REQ-1:0]              o_req_pop,
    input  logic                            i_tmanager_ready,
    output logic                            o_tanswer_ready,
    output logic [DATA_WIDTH-1:0]           o_tanswer_data,
    output logic                            o_tanswer_data_last,
    output logic [SIZE_WIDTH-1:0]           o_packet_size_in_bytes,
    output logic [$clog2(NUM_REQ)-1:0]      o_grant_id,
    output logic                            o_busy,
    output logic                            o_len_error
);

    localparam int          IW         = $clog2(NUM_REQ);
    localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;

    state_e                state_q, state_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]         grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]    grant_oh_q, grant_oh_d;
    logic [SIZE_WIDTH-1:0] size_q, size_d;
    logic [SIZE_WIDTH-1:0] exp_beats_q, exp_beats_d;
    logic [SIZE_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                  len_err_q, len_err_d;
    logic                  busy_q, busy_d;

    logic [NUM_REQ-1:0]    pick_oh;
    logic [IW-1:0]         pick_idx;
    logic                  pick_any;
    logic                  in_xfer;
    logic                  gnt_valid;
    logic                  gnt_last;
    logic                  beat_fire;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req (i_req_valid),
        .i_ptr (rr_ptr_q),
        .o_gnt (pick_oh),
        .o_idx (pick_idx),
        .o_any (pick_any)
    );

    // The channel is a combinational window onto the owner; everything is gated outside XFER.
    assign in_xfer             = (state_q == ST_XFER);
    assign gnt_valid           = |(i_req_valid & grant_oh_q);
    assign gnt_last            = |(i_req_last & grant_oh_q);
    assign o_tanswer_ready     = in_xfer & gnt_valid;
    assign beat_fire           = o_tanswer_ready & i_tmanager_ready;
    assign o_req_pop           = beat_fire ? grant_oh_q : '0;
    assign o_tanswer_data      = in_xfer ? i_req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign o_tanswer_data_last = in_xfer & gnt_last;

    assign o_grant_id             = grant_id_q;
    assign o_packet_size_in_bytes = size_q;
    assign o_busy                 = busy_q;
    assign o_len_error            = len_err_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        grant_oh_d  = grant_oh_q;
        size_d      = size_q;
        exp_beats_d = exp_beats_q;
        beat_cnt_d  = beat_cnt_q;
        len_err_d   = len_err_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_id_d = pick_idx;
                    grant_oh_d = pick_oh;
                    size_d     = i_req_size[int'(pick_idx)*SIZE_WIDTH +: SIZE_WIDTH];
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                exp_beats_d = SIZE_WIDTH'(beats_for_size(32'(size_q), BEAT_BYTES));
                beat_cnt_d  = '0;
                state_d     = ST_XFER;
            end
            ST_XFER: begin
                if (beat_fire) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    // A short or long packet is flagged but never cut off; only last ends it.
                    if (gnt_last) begin
                        if (beat_cnt_d != exp_beats_q) begin
                            len_err_d = 1'b1;
                        end
                        rr_ptr_d = (grant_id_q == IW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                        state_d  = ST_IDLE;
                    end else if (beat_cnt_d == exp_beats_q) begin
                        len_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            grant_oh_q  <= '0;
            size_q      <= '0;
            exp_beats_q <= '0;
            beat_cnt_q  <= '0;
            len_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            grant_oh_q  <= grant_oh_d;
            size_q      <= size_d;
            exp_beats_q <= exp_beats_d;
            beat_cnt_q  <= beat_cnt_d;
            len_err_q   <= len_err_d;
            busy_q      <= busy_d;
        end
    end

endmodule
